fetch_unit: RTL and testbench

Instruction-fetch stage directly upstream of the instruction decoder. It owns the program counter and issues word requests to instruction memory through a request/grant/response handshake. It buffers returned words with their PCs in a small FIFO and presents them to the decode/execute stage through a valid/ready interface. Taken branches and jumps reported back from the control path redirect the PC, flush the buffer, and discard stale in-flight responses.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 61 ++++++
 rtl/fetch_unit.sv | 151 +++++++++++++++
 tb/tb_fetch_unit.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, PC step, default reset PC and the FIFO entry type
// used by the instruction-fetch stage.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Sequential PC; wraps modulo 2^XLEN.
  function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO of {pc, instr} entries sitting between the
// memory response path and the decoder. Flush wins over a same-cycle push.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  fetch_entry_t  i_entry,
  input  logic          i_pop,
  input  logic          i_flush,
  output fetch_entry_t  o_head,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_count   = r_count;
  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_head    = r_mem[r_rptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Pointer and occupancy tracking; flush empties the FIFO and drops any push.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; not reset because the top masks the head while empty.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush && !rst) begin
      r_mem[r_wptr] <= i_entry;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the PC, issues word requests under a
// credit limit of DEPTH (outstanding + buffered), buffers responses in
// fetch_fifo and hands them to decode over valid/ready. Redirects flush the
// buffer and mark every still-outstanding response for discard.
// Optional build macro FETCH_MISALIGN_TRAP_EN: a redirect target with bit 1 set
// raises a sticky fetch_misaligned flag and halts fetching until reset.
// Without it, target bits [1:0] are simply forced to zero.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready,
  input  logic            redirect,
  input  logic            jalr,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fetch_misaligned
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = CW + 1;

  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_resp_pc;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_drop;

  fetch_entry_t    w_head;
  fetch_entry_t    w_push_entry;
  logic [CW-1:0]   w_fifo_count;
  logic            w_fifo_full;
  logic            w_fifo_empty;
  logic            w_pop;
  logic            w_push;
  logic            w_req;
  logic            w_grant;
  logic            w_halted;
  logic [OW-1:0]   w_occupancy;
  logic [CW-1:0]   w_out_next;
  logic [XLEN-1:0] w_target_raw;
  logic [XLEN-1:0] w_target;

  assign w_pop        = instr_valid && instr_ready;
  assign w_target_raw = jalr ? {redirect_pc[XLEN-1:1], 1'b0} : redirect_pc;
  assign w_target     = {w_target_raw[XLEN-1:2], 2'b00};

  // A slot freed by this cycle's pop can be reused by this cycle's request.
  assign w_occupancy  = {1'b0, r_outstanding} + {1'b0, w_fifo_count} - OW'(w_pop);
  assign w_req        = !rst && !w_halted && (w_occupancy < OW'(DEPTH));
  assign w_grant      = w_req && imem_gnt;
  assign w_out_next   = r_outstanding + CW'(w_grant) - CW'(imem_rvalid);

  assign w_push       = imem_rvalid && (r_drop == '0);
  assign w_push_entry = '{pc: r_resp_pc, instr: imem_rdata};

  assign imem_req     = w_req;
  assign imem_addr    = r_fetch_pc;
  assign instr_valid  = !w_fifo_empty;
  assign instr        = instr_valid ? w_head.instr : '0;
  assign instr_pc     = instr_valid ? w_head.pc : '0;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic r_misaligned;
  logic w_unused_bit0;

  assign w_unused_bit0    = w_target_raw[0];
  assign w_halted         = r_misaligned;
  assign fetch_misaligned = r_misaligned;

  // Sticky trap flag: a target with bit 1 set stops all further fetching.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_misaligned <= 1'b0;
    end else if (redirect && w_target_raw[1]) begin
      r_misaligned <= 1'b1;
    end
  end
`else
  logic w_unused_lo;

  assign w_unused_lo      = ^w_target_raw[1:0];
  assign w_halted         = 1'b0;
  assign fetch_misaligned = 1'b0;
`endif

  // PC, response-PC, outstanding and drop bookkeeping. On redirect every
  // request still in flight after this edge (including a same-cycle grant,
  // excluding a same-cycle response) belongs to the old path and is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_drop        <= '0;
    end else begin
      r_outstanding <= w_out_next;
      if (redirect) begin
        r_fetch_pc <= w_target;
        r_resp_pc  <= w_target;
        r_drop     <= w_out_next;
      end else begin
        if (w_grant) begin
          r_fetch_pc <= pc_next(r_fetch_pc);
        end
        if (imem_rvalid) begin
          if (r_drop != '0) begin
            r_drop <= r_drop - 1'b1;
          end else begin
            r_resp_pc <= pc_next(r_resp_pc);
          end
        end
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_entry (w_push_entry),
    .i_pop   (w_pop),
    .i_flush (redirect),
    .o_head  (w_head),
    .o_count (w_fifo_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // The credit limit reserves a slot per request, so a push never finds the
  // FIFO full, and memory never answers more requests than were granted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (redirect || !(w_push && w_fifo_full && !w_pop));
      assert (!(imem_rvalid && (r_outstanding == '0)));
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;
  logic        redirect, jalr;
  logic [31:0] redirect_pc;
  logic        fetch_misaligned;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .redirect(redirect), .jalr(jalr),
    .redirect_pc(redirect_pc), .fetch_misaligned(fetch_misaligned)
  );

  // Second instance starting near the top of the address space.
  logic        w2_req, w2_rvalid, w2_valid, w2_mis;
  logic [31:0] w2_addr, w2_rdata, w2_instr, w2_pc;

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) u_dut_wrap (
    .clk(clk), .rst(rst),
    .imem_req(w2_req), .imem_addr(w2_addr), .imem_gnt(1'b1),
    .imem_rvalid(w2_rvalid), .imem_rdata(w2_rdata),
    .instr_valid(w2_valid), .instr(w2_instr), .instr_pc(w2_pc),
    .instr_ready(1'b1), .redirect(1'b0), .jalr(1'b0),
    .redirect_pc(32'h0), .fetch_misaligned(w2_mis)
  );

  // Memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Wrap instance: always-grant memory with one cycle of latency.
  always @(posedge clk) begin
    w2_rvalid <= w2_req;
    w2_rdata  <= memfn(w2_addr);
  end

  logic [31:0] wrap_pc_q[$];
  logic [31:0] wrap_ins_q[$];
  always @(negedge clk) begin
    if (rst === 1'b0 && w2_valid === 1'b1 && wrap_pc_q.size() < 3) begin
      wrap_pc_q.push_back(w2_pc);
      wrap_ins_q.push_back(w2_instr);
    end
  end

  // Memory model and reference stream model for the main instance.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  int          cyc = 0;
  int unsigned gnt_pct = 100;
  int unsigned lat_lo = 1;
  int unsigned lat_hi = 1;
  logic [31:0] exp_pc, exp_faddr;
  bit          redir_prev;
  int          n_pop = 0;

  logic        s_req, s_gnt, s_rv, s_v, s_mis;
  logic [31:0] s_addr, s_pc, s_ins;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    instr_ready = 1'b0; redirect = 1'b0; jalr = 1'b0; redirect_pc = '0;
    mq.delete();
    exp_pc = 32'h0; exp_faddr = 32'h0; redir_prev = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req",   32'(imem_req), 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc",    instr_pc, 32'h0);
    chk("rst_mis",   32'(fetch_misaligned), 32'h0);
    chk("rst_addr",  imem_addr, 32'h0);
    rst = 1'b0;
  endtask

  // One clock cycle: drive inputs at the falling edge, sample, check the
  // delivered stream against program order and the request addresses against
  // the expected fetch path, then let the rising edge happen.
  task automatic step(input bit rdy, input bit rd, input bit jl, input logic [31:0] rpc);
    logic [31:0] t;
    @(negedge clk);
    instr_ready = rdy; redirect = rd; jalr = jl; redirect_pc = rpc;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memfn(mq[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    imem_gnt = ($urandom_range(99) < gnt_pct);
    #1;
    s_req = imem_req; s_addr = imem_addr; s_v = instr_valid;
    s_pc = instr_pc; s_ins = instr; s_mis = fetch_misaligned;
    s_gnt = s_req && imem_gnt;
    s_rv  = imem_rvalid;
    if (redir_prev) chk("flush_valid", 32'(s_v), 32'h0);
    if (s_req) chk("addr_align", 32'(s_addr[1:0]), 32'h0);
    if (s_v && rdy) begin
      chk("instr_pc", s_pc, exp_pc);
      chk("instr", s_ins, memfn(s_pc));
      exp_pc = exp_pc + 32'd4;
      n_pop++;
    end
    if (s_gnt) begin
      chk("imem_addr", s_addr, exp_faddr);
      exp_faddr = exp_faddr + 32'd4;
      mq.push_back('{addr: s_addr, due: cyc + int'($urandom_range(lat_hi, lat_lo))});
    end
    if (s_rv) void'(mq.pop_front());
    chk("credit", 32'(mq.size() <= DEPTH), 32'h1);
    if (rd) begin
      t = rpc & ~32'h3;
      exp_pc = t;
      exp_faddr = t;
    end
    redir_prev = rd;
    @(posedge clk);
    cyc++;
  endtask

  task automatic wait_valid(input string tag, input int maxc);
    bit found;
    found = 1'b0;
    for (int i = 0; i < maxc && !found; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      found = s_v;
    end
    chk(tag, 32'(found), 32'h1);
  endtask

  task automatic wait_req(input string tag, input int maxc);
    bit found;
    found = 1'b0;
    for (int i = 0; i < maxc && !found; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      found = s_req;
    end
    chk(tag, 32'(found), 32'h1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int grants;
    int pops0;
    logic [31:0] wexp [3];
    wexp[0] = 32'hFFFF_FFF8; wexp[1] = 32'hFFFF_FFFC; wexp[2] = 32'h0000_0000;

    // Streaming from reset: one instruction per cycle, first two cycles empty.
    do_reset();
    gnt_pct = 100; lat_lo = 1; lat_hi = 1;
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      if (k < 2) chk("t1_empty", 32'(s_v), 32'h0);
      else begin
        chk("t1_valid", 32'(s_v), 32'h1);
        chk("t1_pc", s_pc, 32'(4 * (k - 2)));
      end
    end

    // Stall: credit limits requests to DEPTH; release resumes at 8.
    do_reset();
    grants = 0;
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      if (s_gnt) grants++;
    end
    chk("t2_grants", 32'(grants), 32'(DEPTH));
    chk("t2_req_off", 32'(s_req), 32'h0);
    chk("t2_head_pc", s_pc, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("t2_rel_pc", s_pc, 32'h0);
    chk("t2_rel_req", 32'(s_req), 32'h1);
    chk("t2_rel_addr", s_addr, 32'h8);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("t2_second_pc", s_pc, 32'h4);

    // Redirect with two requests in flight: both responses discarded.
    do_reset();
    lat_lo = 3; lat_hi = 3;
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h100);
    chk("t3_inflight", 32'(mq.size()), 32'h2);
    wait_valid("t3_timeout", 30);
    chk("t3_first", s_pc, 32'h100);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("t3_second_v", 32'(s_v), 32'h1);
    chk("t3_second", s_pc, 32'h104);

    // jalr clears bit 0 of the target.
    do_reset();
    lat_lo = 1; lat_hi = 1;
    repeat (4) step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h201);
    wait_req("t4_req_timeout", 10);
    chk("t4_jalr_addr", s_addr, 32'h200);
`ifdef FETCH_MISALIGN_TRAP_EN
    step(1'b1, 1'b1, 1'b1, 32'h202);
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      chk("t4_mis_flag", 32'(s_mis), 32'h1);
      chk("t4_mis_req", 32'(s_req), 32'h0);
    end
`else
    step(1'b1, 1'b1, 1'b0, 32'h202);
    wait_req("t4b_req_timeout", 10);
    chk("t4b_addr", s_addr, 32'h200);
    chk("t4b_mis", 32'(s_mis), 32'h0);
    wait_valid("t4b_valid_timeout", 20);
    chk("t4b_pc", s_pc, 32'h200);
`endif

    // Redirect coinciding with a grant and a response.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h300);
    chk("t5_gnt", 32'(s_gnt), 32'h1);
    chk("t5_rv", 32'(s_rv), 32'h1);
    wait_valid("t5_timeout", 20);
    chk("t5_first", s_pc, 32'h300);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("t5_second", s_pc, 32'h304);

    // Randomized traffic against the stream model.
    do_reset();
    gnt_pct = 70; lat_lo = 1; lat_hi = 4;
    pops0 = n_pop;
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(3) != 0, $urandom_range(24) == 0, 1'($urandom),
           $urandom & ~32'h2);
    end
    chk("rand_progress", 32'((n_pop - pops0) > 200), 32'h1);

    // PC wrap on the second instance.
    chk("wrap_count", 32'(wrap_pc_q.size()), 32'h3);
    for (int i = 0; i < 3; i++) begin
      if (i < wrap_pc_q.size()) begin
        chk("wrap_pc", wrap_pc_q[i], wexp[i]);
        chk("wrap_instr", wrap_ins_q[i], memfn(wexp[i]));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
